// File: rtl/spi_dac_receiver.sv
// Oversampling SPI receiver for the DAC links: rebuilds each chip-select frame into a
// WORD_BITS command word, splits config/sample fields and flags framing errors.
module spi_dac_receiver #(
  parameter int unsigned WORD_BITS = 16
) (
  input  logic                 clock_in,
  input  logic                 reset_in,
  input  logic                 sclk_in,
  input  logic                 mosi_in,
  input  logic                 cs_in,
  output logic [WORD_BITS-1:0] data_out,
  output logic [3:0]           config_out,
  output logic [WORD_BITS-5:0] value_out,
  output logic                 valid_out,
  output logic                 error_out,
  output logic [15:0]          word_count
);

  localparam int unsigned CntW = $clog2(WORD_BITS) + 2;
  localparam logic [CntW-1:0] CntFull = CntW'(WORD_BITS);
  localparam logic [CntW-1:0] CntSat  = CntW'(WORD_BITS + 1);

  typedef enum logic [1:0] {StWait, StIdle, StShift} state_e;

  // Bit 0 = s1, bit 1 = s2, bit 2 = s3. Data is taken from s2, so mosi needs no third stage.
  logic [2:0] sclk_sync, cs_sync;
  logic [1:0] mosi_sync;
  logic       sclk_rise, cs_rise, cs_fall, mosi_bit;

  state_e                state_q, state_d;
  logic [WORD_BITS-1:0]  shift_q, shift_d, shift_upd;
  logic [CntW-1:0]       cnt_q, cnt_d, cnt_upd;
  logic [WORD_BITS-1:0]  data_q;
  logic [15:0]           word_count_q;
  logic                  valid_q, error_q;
  logic                  capture, frame_err;

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[1:0], sclk_in};
      cs_sync   <= {cs_sync[1:0], cs_in};
      mosi_sync <= {mosi_sync[0], mosi_in};
    end
  end

  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign cs_rise   = cs_sync[1] & ~cs_sync[2];
  assign cs_fall   = ~cs_sync[1] & cs_sync[2];
  assign mosi_bit  = mosi_sync[1];

  // State register.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) state_q <= StWait;
    else          state_q <= state_d;
  end

  // Next-state logic. WAIT swallows any frame already running when reset is released.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWait:  if (cs_sync[1]) state_d = StIdle;
      StIdle:  if (cs_fall)    state_d = StShift;
      StShift: if (cs_rise)    state_d = StIdle;
      default: state_d = StWait;
    endcase
  end

  assign shift_upd = {shift_q[WORD_BITS-2:0], mosi_bit};
  assign cnt_upd   = (cnt_q == CntSat) ? cnt_q : cnt_q + CntW'(1);

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (state_q == StIdle && cs_fall) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (state_q == StShift && sclk_rise) begin
      shift_d = shift_upd;
      cnt_d   = cnt_upd;
    end
  end

  // Output decode: a same-cycle sclk edge is already folded into cnt_d.
  always_comb begin
    capture   = 1'b0;
    frame_err = 1'b0;
    if (state_q == StShift && cs_rise) begin
      capture   = (cnt_d == CntFull);
      frame_err = (cnt_d != CntFull);
    end
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      shift_q      <= '0;
      cnt_q        <= '0;
      data_q       <= '0;
      word_count_q <= '0;
      valid_q      <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      valid_q <= capture;
      error_q <= frame_err;
      if (capture) begin
        data_q       <= shift_d;
        word_count_q <= word_count_q + 16'd1;
      end
    end
  end

  assign data_out   = data_q;
  assign config_out = data_q[WORD_BITS-1:WORD_BITS-4];
  assign value_out  = data_q[WORD_BITS-5:0];
  assign valid_out  = valid_q;
  assign error_out  = error_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_spi_dac_receiver.sv
// Directed + randomized bench for spi_dac_receiver against a frame-level reference model.
module tb_spi_dac_receiver;
  localparam int W = 16;

  logic          clock_in = 1'b0;
  logic          reset_in = 1'b1;
  logic          sclk_in  = 1'b0;
  logic          mosi_in  = 1'b0;
  logic          cs_in    = 1'b1;
  logic [W-1:0]  data_out;
  logic [3:0]    config_out;
  logic [W-5:0]  value_out;
  logic          valid_out;
  logic          error_out;
  logic [15:0]   word_count;

  spi_dac_receiver #(.WORD_BITS(W)) dut (
    .clock_in   (clock_in),
    .reset_in   (reset_in),
    .sclk_in    (sclk_in),
    .mosi_in    (mosi_in),
    .cs_in      (cs_in),
    .data_out   (data_out),
    .config_out (config_out),
    .value_out  (value_out),
    .valid_out  (valid_out),
    .error_out  (error_out),
    .word_count (word_count)
  );

  always #5 clock_in = ~clock_in;

  int cyc = 0;
  always @(posedge clock_in) cyc <= cyc + 1;

  int n_tests = 0, n_fail = 0;
  int n_valid = 0, n_err = 0;
  int valid_cycs[$];

  // Reference model state: frame-level outcome only.
  logic [15:0] m_data = '0;
  logic [15:0] m_count = '0;
  int exp_valid = 0, exp_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock_in) begin
    if (valid_out || error_out) begin
      if (valid_out) begin
        n_valid++;
        valid_cycs.push_back(cyc);
      end
      if (error_out) n_err++;
      check("exclusive", {31'b0, valid_out & error_out}, 32'd0);
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock_in);
  endtask

  // Caller is at a negedge. cs_cyc is the cycle count when cs is raised.
  task automatic send_frame(input logic [31:0] bits, input int n, input int half,
                            output int cs_cyc);
    cs_in = 1'b0;
    wait_cyc(2);
    if (n == 0) wait_cyc(8);
    for (int i = n - 1; i >= 0; i--) begin
      mosi_in = bits[i];
      sclk_in = 1'b0;
      wait_cyc(half);
      sclk_in = 1'b1;
      wait_cyc(half);
    end
    sclk_in = 1'b0;
    wait_cyc(2);
    cs_in  = 1'b1;
    cs_cyc = cyc;
    wait_cyc(2);
  endtask

  task automatic model_frame(input logic [31:0] bits, input int n);
    if (n == W) begin
      m_data  = bits[15:0];
      m_count = m_count + 16'd1;
      exp_valid++;
    end else begin
      exp_err++;
    end
  endtask

  task automatic frame(input logic [31:0] bits, input int n, input int half);
    int c;
    send_frame(bits, n, half, c);
    model_frame(bits, n);
  endtask

  task automatic check_state(input string tag);
    wait_cyc(6);
    check({tag, ".valids"}, n_valid, exp_valid);
    check({tag, ".errors"}, n_err, exp_err);
    check({tag, ".data"}, {16'b0, data_out}, {16'b0, m_data});
    check({tag, ".config"}, {28'b0, config_out}, {28'b0, m_data[15:12]});
    check({tag, ".value"}, {20'b0, value_out}, {20'b0, m_data[11:0]});
    check({tag, ".count"}, {16'b0, word_count}, {16'b0, m_count});
  endtask

  initial begin
    int c1, c2, n, half;
    logic [31:0] bits;

    wait_cyc(3);
    check("rst_data", {16'b0, data_out}, 32'd0);
    check("rst_pulses", {30'b0, valid_out, error_out}, 32'd0);
    reset_in = 1'b0;
    wait_cyc(4);

    // Reset mid-frame after one good word.
    frame(32'h1234, 16, 2);
    check_state("pre_reset");
    cs_in = 1'b0;
    wait_cyc(2);
    for (int i = 0; i < 8; i++) begin
      mosi_in = i[0];
      sclk_in = 1'b0;
      wait_cyc(2);
      sclk_in = 1'b1;
      wait_cyc(2);
    end
    #2 reset_in = 1'b1;
    #1;
    check("inrst_data", {16'b0, data_out}, 32'd0);
    check("inrst_config", {28'b0, config_out}, 32'd0);
    check("inrst_value", {20'b0, value_out}, 32'd0);
    check("inrst_count", {16'b0, word_count}, 32'd0);
    check("inrst_pulses", {30'b0, valid_out, error_out}, 32'd0);
    m_data  = '0;
    m_count = '0;
    sclk_in = 1'b0;
    wait_cyc(2);
    reset_in = 1'b0;
    wait_cyc(3);
    cs_in = 1'b1;
    wait_cyc(4);
    frame(32'h3ABC, 16, 2);
    check_state("after_reset");

    // Latency with back-to-back frames and a two-cycle cs high gap.
    valid_cycs.delete();
    send_frame(32'h7FFF, 16, 2, c1);
    model_frame(32'h7FFF, 16);
    send_frame(32'h0001, 16, 2, c2);
    model_frame(32'h0001, 16);
    check_state("latency");
    check("lat_pulses", valid_cycs.size(), 32'd2);
    check("lat_first", (valid_cycs.size() > 0) ? valid_cycs[0] : -1, c1 + 3);
    check("lat_second", (valid_cycs.size() > 1) ? valid_cycs[1] : -1, c2 + 3);

    // Short, long and empty frames.
    frame($urandom, 15, 2);
    check_state("short");
    frame($urandom, 17, 2);
    frame(32'h0, 0, 2);
    check_state("long_empty");

    // Randomized frames: mostly good words, some off-by-one lengths.
    for (int k = 0; k < 10; k++) begin
      bits = $urandom;
      case ($urandom_range(0, 4))
        0: n = 15;
        1: n = 17;
        default: n = 16;
      endcase
      half = $urandom_range(2, 4);
      frame(bits, n, half);
      check_state("random");
    end

    // Reset released while a frame is already running: nothing is reported.
    reset_in = 1'b1;
    cs_in    = 1'b0;
    wait_cyc(2);
    for (int i = 0; i < 16; i++) begin
      if (i == 6) reset_in = 1'b0;
      mosi_in = 1'b1;
      sclk_in = 1'b0;
      wait_cyc(2);
      sclk_in = 1'b1;
      wait_cyc(2);
    end
    sclk_in = 1'b0;
    wait_cyc(2);
    cs_in = 1'b1;
    wait_cyc(2);
    m_data  = '0;
    m_count = '0;
    check_state("start_in_frame");
    frame(32'hFFFF, 16, 2);
    check_state("after_wait");

    // Counter wrap.
    force dut.word_count_q = 16'hFFFF;
    wait_cyc(1);
    release dut.word_count_q;
    m_count = 16'hFFFF;
    frame($urandom, 16, 3);
    check_state("wrap");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
